tft_spi_arbiter: RTL

- Shares one write-only SPI link to the Adafruit TFT between two FPGA-side requesters, e.g. an HPS-fed PIO bridge and a kernel-side overlay engine.
- Arbitrates round-robin at burst boundaries and serialises 8-bit command/data words (SPI mode 0, MSB first).
- Drives TFT chip-select and the D/C line; sits between the requester logic and the TFT pins.

---
 rtl/tft_spi_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/tft_spi_arbiter.sv
// Two-requester round-robin arbiter feeding a write-only SPI (mode 0, MSB first) link to a TFT.
// Define TFT_SPI_ARB_FIXED_PRIO_EN to give requester 0 fixed priority on IDLE ties.
module tft_spi_arbiter #(
  parameter int CLK_DIV   = 4,
  parameter int BURST_MAX = 16,
  parameter int CS_GAP    = 2
) (
  input  logic       fpga_clk_50,
  input  logic       fpga_reset_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_dc,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_dc,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       tft_sclk,
  output logic       tft_mosi,
  output logic       tft_cs_n,
  output logic       tft_dc,
  output logic [1:0] grant,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_e;

  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [7:0] BURST_LIM = 8'(BURST_MAX);
  localparam logic [3:0] GAP_LAST  = 4'(CS_GAP - 1);

  state_e     state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic [3:0] gap_q, gap_d;
  logic [7:0] shreg_q, shreg_d;
  logic       last_q, last_d;
  logic       owner_q, owner_d;
  logic       served_q, served_d;
  logic [1:0] grant_q, grant_d;
  logic       sclk_q, sclk_d;
  logic       mosi_q, mosi_d;
  logic       cs_n_q, cs_n_d;
  logic       dc_q, dc_d;

  logic       pick;
  logic       sel;
  logic [7:0] sel_data;
  logic       sel_dc;
  logic       sel_last;
  logic       own_valid;
  logic       load_word;

  // pick is the requester index chosen in IDLE when at least one is valid
`ifdef TFT_SPI_ARB_FIXED_PRIO_EN
  assign pick = ~req0_valid;
`else
  assign pick = (req0_valid && req1_valid) ? ~served_q : ~req0_valid;
`endif

  assign sel       = (state_q == IDLE) ? pick : owner_q;
  assign sel_data  = sel ? req1_data : req0_data;
  assign sel_dc    = sel ? req1_dc   : req0_dc;
  assign sel_last  = sel ? req1_last : req0_last;
  assign own_valid = owner_q ? req1_valid : req0_valid;

  always_ff @(posedge fpga_clk_50 or negedge fpga_reset_n) begin
    if (!fpga_reset_n) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      wcnt_q   <= '0;
      gap_q    <= '0;
      shreg_q  <= '0;
      last_q   <= 1'b0;
      owner_q  <= 1'b0;
      served_q <= 1'b1;
      grant_q  <= 2'b00;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      dc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      wcnt_q   <= wcnt_d;
      gap_q    <= gap_d;
      shreg_q  <= shreg_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      served_q <= served_d;
      grant_q  <= grant_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      cs_n_q   <= cs_n_d;
      dc_q     <= dc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    wcnt_d    = wcnt_q;
    gap_d     = gap_q;
    shreg_d   = shreg_q;
    last_d    = last_q;
    owner_d   = owner_q;
    served_d  = served_q;
    grant_d   = grant_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    dc_d      = dc_q;
    load_word = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          owner_d   = pick;
          grant_d   = pick ? 2'b10 : 2'b01;
          load_word = 1'b1;
        end
      end
      LOAD: begin
        state_d = SHIFT;
        div_d   = '0;
        bit_d   = 3'd7;
      end
      SHIFT: begin
        if (div_q != DIV_LAST) begin
          div_d = div_q + 8'd1;
        end else begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else if (bit_q != 3'd0) begin
            sclk_d  = 1'b0;
            bit_d   = bit_q - 3'd1;
            shreg_d = {shreg_q[6:0], 1'b0};
            mosi_d  = shreg_q[6];
          end else if (!last_q && (wcnt_q < BURST_LIM) && own_valid) begin
            load_word = 1'b1;
          end else begin
            state_d  = GAP;
            cs_n_d   = 1'b1;
            sclk_d   = 1'b0;
            mosi_d   = 1'b0;
            served_d = owner_q;
            wcnt_d   = '0;
            grant_d  = 2'b00;
            gap_d    = '0;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_d = IDLE;
        else                   gap_d   = gap_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase

    // Word capture happens on the edge into LOAD so the first bit is on the pins during LOAD
    if (load_word) begin
      state_d = LOAD;
      shreg_d = sel_data;
      dc_d    = sel_dc;
      last_d  = sel_last;
      mosi_d  = sel_data[7];
      cs_n_d  = 1'b0;
      sclk_d  = 1'b0;
      wcnt_d  = (wcnt_q == BURST_LIM) ? wcnt_q : wcnt_q + 8'd1;
    end
  end

  assign req0_ready = (state_q == LOAD) && !owner_q;
  assign req1_ready = (state_q == LOAD) &&  owner_q;
  assign tft_sclk   = sclk_q;
  assign tft_mosi   = mosi_q;
  assign tft_cs_n   = cs_n_q;
  assign tft_dc     = dc_q;
  assign grant      = grant_q;
  assign busy       = (state_q != IDLE);

endmodule
